// File: rtl/drm_32x1024_arb_pkg.sv
// Shared constants and FSM encoding for the 32x1024 RAM arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package drm_arb_pkg;

  localparam int DRM_ADDR_W = 10;
  localparam int DRM_DATA_W = 32;
  localparam int DRM_DEPTH  = 1024;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/drm_32x1024_arb_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time wins.
// Latency: grant is combinational from req_i; last-grant state updates on the clock edge.
// Backpressure: en_i low suppresses all grants and freezes the last-grant state.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  // Index of the most recent grantee; 1 after reset so requester 0 wins the first tie.
  logic last_q;
  logic last_d;

  // Pick a winner from the current requests.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Remember the winner whenever something is granted.
  always_comb begin
    last_d = last_q;
    if (|grant_o) begin
      last_d = grant_o[1];
    end
  end

  // Last-grant register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/drm_32x1024_arb.sv
// Zero-fills the RAM after reset, then round-robins two requesters onto its write and read ports.
// Latency: write/read grants combinational; read response one cycle after accept (bypass on same-address write).
// Backpressure: reqN_ready is low during INIT and whenever the other requester wins the port.
module drm_32x1024_arb
  import drm_arb_pkg::*;
#(
  parameter int ADDR_W     = DRM_ADDR_W,
  parameter int DATA_W     = DRM_DATA_W,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              init_done_q;

  logic              run;
  logic              init_wr;
  logic [1:0]        wr_req;
  logic [1:0]        rd_req;
  logic [1:0]        wr_gnt;
  logic [1:0]        rd_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] r_addr;
  logic              collide;
  logic [DATA_W-1:0] rsp_dat;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        rsp_vld_q;
  logic              byp_q;
  logic [DATA_W-1:0] byp_dat_q;
  logic [DATA_W-1:0] hold0_q;
  logic [DATA_W-1:0] hold1_q;

  // Reset is folded in so every output reads 0 while reset is asserted.
  assign run     = (state_q == ST_RUN) && !rst;
  assign init_wr = (state_q == ST_INIT) && !rst;

  assign wr_req = {req1_valid &  req1_we, req0_valid &  req0_we};
  assign rd_req = {req1_valid & ~req1_we, req0_valid & ~req0_we};

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (run),
    .req_i   (wr_req),
    .grant_o (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (run),
    .req_i   (rd_req),
    .grant_o (rd_gnt)
  );

  assign req0_ready = wr_gnt[0] | rd_gnt[0];
  assign req1_ready = wr_gnt[1] | rd_gnt[1];
  assign init_done  = init_done_q;

  // Select the winning write/read request fields and drive the RAM ports.
  always_comb begin
    w_addr      = wr_gnt[1] ? req1_addr  : req0_addr;
    w_data      = wr_gnt[1] ? req1_wdata : req0_wdata;
    r_addr      = rd_gnt[1] ? req1_addr  : req0_addr;
    collide     = (|wr_gnt) && (|rd_gnt) && (w_addr == r_addr);
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (init_wr) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = clr_cnt_q;
    end else if (|wr_gnt) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = w_addr;
      ram_wr_data = w_data;
    end
    ram_rd_addr = (|rd_gnt) ? r_addr : rd_addr_q;
  end

  // The RAM is read-first, so a same-cycle same-address write must be served from the bypass copy.
  assign rsp_dat    = byp_q ? byp_dat_q : ram_rd_data;
  assign rsp0_valid = rsp_vld_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp0_rdata = rsp_vld_q[0] ? rsp_dat : hold0_q;
  assign rsp1_rdata = rsp_vld_q[1] ? rsp_dat : hold1_q;

  // Init/run sequencer: clear every address once, then run until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT_CLEAR ? ST_INIT : ST_RUN;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Read-side bookkeeping: held read address, response owner, bypass capture, per-requester data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      rsp_vld_q <= 2'b00;
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
      hold0_q   <= '0;
      hold1_q   <= '0;
    end else begin
      if (|rd_gnt) begin
        rd_addr_q <= r_addr;
      end
      rsp_vld_q <= rd_gnt;
      byp_q     <= collide;
      if (collide) begin
        byp_dat_q <= w_data;
      end
      if (rsp_vld_q[0]) begin
        hold0_q <= rsp_dat;
      end
      if (rsp_vld_q[1]) begin
        hold1_q <= rsp_dat;
      end
    end
  end

endmodule

// File: doc/drm_32x1024_arb.md
# drm_32x1024_arb

Two-requester arbiter and initialization sequencer for the 32x1024 simple dual-port block RAM (`drm_32x1024`, 1-cycle read latency, no output register). It owns the RAM's write and read ports. After reset it zero-fills the RAM. It then grants write and read accesses independently with per-port round-robin, and returns read data to the requester that won. It sits between the RAM instance and two client engines in the same clock domain.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width (depth 2^ADDR_W).
- `DATA_W`, 32: RAM data width.
- `INIT_CLEAR`, 1: 1 = zero-fill RAM after reset; 0 = go straight to RUN.

Ports (`N` in {0,1}):
- `clk` in 1: single clock; drives RAM `wr_clk` and `rd_clk`.
- `rst` in 1: asynchronous, active-high reset; also drives RAM `wr_rst` and `rd_rst`.
- `init_done` out 1: high once clearing is finished.
- `reqN_valid` in 1: request N present.
- `reqN_we` in 1: 1 = write, 0 = read.
- `reqN_addr` in ADDR_W: request address.
- `reqN_wdata` in DATA_W: write data.
- `reqN_ready` out 1: request N accepted this cycle.
- `rspN_valid` out 1: read data for requester N is valid.
- `rspN_rdata` out DATA_W: read data.
- `ram_wr_en`, `ram_wr_addr`, `ram_wr_data` out 1/ADDR_W/DATA_W: drive the RAM write port.
- `ram_rd_addr` out ADDR_W: drives the RAM read address.
- `ram_rd_data` in DATA_W: RAM read data.

## Operation
- FSM states: INIT and RUN.
- On reset:
  - State is INIT if `INIT_CLEAR`=1, else RUN.
  - `clr_cnt` = 0.
  - Write and read last-grant registers = 1, so requester 0 wins the first tie.
  - All outputs are 0, including `init_done`, `reqN_ready`, `rspN_valid`, `rspN_rdata` and `ram_*`.
- INIT:
  - Drive `ram_wr_en`=1, `ram_wr_addr`=`clr_cnt`, `ram_wr_data`=0.
  - `clr_cnt` increments every cycle.
  - On `clr_cnt`=2^ADDR_W-1, go to RUN. `init_done` rises the next cycle and stays high until reset.
  - `reqN_ready` is 0 throughout INIT.
- RUN, write port:
  - Candidates are the requesters with `valid & we`.
  - With one candidate, grant it.
  - With two, grant the one that is not the last write grantee.
  - Update the last write grantee on every grant.
- RUN, read port: same rule, applied independently to `valid & !we` candidates using the read last-grant register.
- At most one write and one read are granted per cycle.
- `reqN_ready` is combinational: RUN & (granted on either port).
- Requesters hold valid, we, addr and wdata stable until ready.
- Writes:
  - A granted write drives `ram_wr_en`/`ram_wr_addr`/`ram_wr_data` combinationally in the same cycle.
  - `ram_wr_en`=0 when no write is granted.
- Reads:
  - A granted read drives `ram_rd_addr` combinationally.
  - `ram_rd_addr` holds its last value when idle.
  - The grantee id is registered for the response.
- Read-during-write collision:
  - Case: a write and a read to the same address are granted in the same cycle.
  - Register a bypass flag plus the write data.
  - The response returns the new write data, not `ram_rd_data`.
- Reset mid-operation: any in-flight response is dropped and the FSM restarts INIT. Clients must reissue their requests.

## Timing
- A read accepted in cycle T gives `rspN_valid`=1 in cycle T+1 for exactly one cycle, with `rspN_rdata` valid in that cycle.
- Back-to-back reads sustain one response per cycle.
- A write accepted in T is visible to a read accepted in T+1 or later through the RAM.
- A write and a read accepted in the same cycle T are served by the bypass path.
- With `INIT_CLEAR`=1:
  - `init_done` rises 2^ADDR_W+1 cycles after `rst` falls.
  - The first grant is possible in the cycle after the last clear write.
- With `INIT_CLEAR`=0: `init_done`=1 from the first cycle after reset.
- Starvation bound: a waiting requester is granted within 2 cycles while it holds valid.
- `rspN_rdata` holds its value between responses.

## Structure
- Package `drm_arb_pkg`:
  - Constants: `DRM_ADDR_W`=10, `DRM_DATA_W`=32, `DRM_DEPTH`=1024.
  - FSM state encoding: INIT=0, RUN=1.
- Sub-module `rr_arb2`:
  - 2-way round-robin arbiter: req[1:0] in, grant[1:0] out, last-grant register inside, updates on grant.
  - Instantiated twice, once for the write port and once for the read port.
- RAM instantiation stays in the parent wrapper, not in this block.

## Test plan
- Reset release with `INIT_CLEAR`=1 -> 1024 writes of 0 to addresses 0..1023; `init_done`=1 at cycle 1025; read of addr 0x3FF -> 0.
- req0 writes 0xDEADBEEF to 0x010, then req1 reads 0x010 -> `rsp1_valid` one cycle after accept, `rsp1_rdata`=0xDEADBEEF, `rsp0_valid` stays 0.
- Both requesters hold continuous reads -> grants alternate 0,1,0,1 starting with 0; each `rspN_valid` arrives at T+1.
- Same cycle: req0 writes 0xA5A5A5A5 to 0x020 while req1 reads 0x020 (old content 0) -> `rsp1_rdata`=0xA5A5A5A5.
- Same cycle: req0 writes to 0x030 and req1 reads 0x040 -> both ready=1 in the same cycle, independent grants.
- Assert `rst` while a read response is pending -> no `rspN_valid`; outputs 0; INIT restarts from address 0.
